feature_packer: RTL

FEATURE_PACKER -- requirements
Module: feature_packer

---
 rtl/feature_packer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/feature_packer.sv
// Packs a stream of PRECISION-bit elements into registered NUM_FEATURES x N examples.
// Define FEATURE_PACKER_DBUF_EN for two-bank ping-pong buffering; the default build uses one bank.
module feature_packer #(
    parameter int unsigned PRECISION    = 8,
    parameter int unsigned NUM_FEATURES = 1,
    parameter int unsigned N            = 24
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            ce,
    input  logic                                            in_valid,
    output logic                                            in_ready,
    input  logic [PRECISION-1:0]                            in_data,
    input  logic                                            in_last,
    output logic                                            out_valid,
    input  logic                                            out_ready,
    output logic [NUM_FEATURES-1:0][N-1:0][PRECISION-1:0]   features,
    output logic                                            err
);
    localparam int unsigned TOTAL = NUM_FEATURES * N;
    localparam int unsigned IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
`ifdef FEATURE_PACKER_DBUF_EN
    localparam int unsigned NBANK = 2;
`else
    localparam int unsigned NBANK = 1;
`endif
    localparam logic [1:0] DEPTH = 2'(NBANK);

    // Element k sits at flat index k, which matches features[k/N][k%N] bit-for-bit.
    typedef logic [TOTAL-1:0][PRECISION-1:0] flat_t;
    typedef enum logic {FILL, FULL} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:0]       count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic             err_q, err_d;
    flat_t            features_q, features_d;
    flat_t            bank_q [NBANK];
    flat_t            bank_d [NBANK];
    logic             wr_sel;
    logic             push, pop, final_elem, done;
    flat_t            completed;

`ifdef FEATURE_PACKER_DBUF_EN
    logic wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
    assign wr_sel = wr_sel_q;
`else
    assign wr_sel = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        count_d     = count_q;
        err_d       = 1'b0;
        features_d  = features_q;
        bank_d      = bank_q;
`ifdef FEATURE_PACKER_DBUF_EN
        wr_sel_d    = wr_sel_q;
        rd_sel_d    = rd_sel_q;
`endif
        in_ready    = rst && ce && (state_q == FILL);
        push        = in_valid && in_ready;
        pop         = out_valid_q && out_ready && ce;
        final_elem  = (idx_q == IDX_W'(TOTAL - 1));
        done        = push && final_elem;
        completed   = bank_q[wr_sel];
        completed[idx_q] = in_data;

        if (push) begin
            bank_d[wr_sel] = completed;
            if (final_elem) begin
                idx_d = '0;
                err_d = ~in_last;
            end else if (in_last) begin
                idx_d = '0;
                err_d = 1'b1;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end

        if (done && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !done) begin
            count_d = count_q - 2'd1;
        end

        // The presented example changes when a new one completes into an empty (or draining)
        // queue, or when the head is popped while the other bank already holds a complete one.
        if (done && ((count_q == 2'd0) || pop)) begin
            features_d = completed;
        end
`ifdef FEATURE_PACKER_DBUF_EN
        else if (pop && (count_q == 2'd2)) begin
            features_d = bank_q[~rd_sel_q];
        end
        if (done) wr_sel_d = ~wr_sel_q;
        if (pop)  rd_sel_d = ~rd_sel_q;
`endif

        out_valid_d = (count_d != 2'd0);
        state_d     = (count_d == DEPTH) ? FULL : FILL;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FILL;
            idx_q       <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            features_q  <= '0;
            bank_q      <= '{default: '0};
`ifdef FEATURE_PACKER_DBUF_EN
            wr_sel_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
`endif
        end else if (ce) begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            features_q  <= features_d;
            bank_q      <= bank_d;
`ifdef FEATURE_PACKER_DBUF_EN
            wr_sel_q    <= wr_sel_d;
            rd_sel_q    <= rd_sel_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign err       = err_q;
    assign features  = features_q;

endmodule
